iter_div: RTL and testbench

//  Iterative radix-2 restoring divider; the division counterpart of the combinational Booth/Wallace multiplier in EXU.

---
 rtl/iter_div_if.sv | 36 +++
 rtl/iter_div.sv | 225 ++++++++++++++++++++++
 tb/tb_iter_div.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_div_if.sv
// ---------------------------------------------------------------------------
// iter_div_if
//   Request/response bundle for the iterative divider.
//   master : execution-unit side (drives operands, consumes results)
//   slave  : divider side
//   Signals
//     in_valid / in_ready     request handshake
//     rs1_data / rs2_data     dividend / divisor
//     div_signed / div_word   operation flavour
//     out_valid / out_ready   result handshake
//     quotient / remainder    results (both returned, consumer selects)
// ---------------------------------------------------------------------------
interface iter_div_if #(
    parameter int XLEN = 64
) ();
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            div_signed;
    logic            div_word;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

    modport master (
        output in_valid, rs1_data, rs2_data, div_signed, div_word, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, rs1_data, rs2_data, div_signed, div_word, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/iter_div.sv
// ---------------------------------------------------------------------------
// iter_div
//   Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the
//   32-bit W variants. One quotient bit per cycle; quotient and remainder are
//   returned together.
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     flush   kills any in-flight operation (highest priority)
//     bus     iter_div_if.slave: valid/ready request and response channels
//   Sequence: IDLE -> CALC (N cycles) -> FIX -> DONE -> IDLE.
//   Divide-by-zero and signed overflow go straight from IDLE to DONE.
// ---------------------------------------------------------------------------
module iter_div #(
    parameter int XLEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    iter_div_if.slave  bus
);

    localparam int              CW        = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_DWORD = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_WORD  = CW'(32'd31);
    localparam logic [XLEN-1:0] ZERO      = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_DWORD = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_WORD  = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Sign-extend a 32-bit value to the full register width.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    state_t          state_r;
    state_t          state_next;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] dvd_r;      // dividend shifts out the top, quotient bits shift in the bottom
    logic [XLEN-1:0] dsr_r;      // divisor magnitude
    logic [XLEN-1:0] rem_r;      // partial remainder
    logic            word_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic [XLEN-1:0] quo_out_r;
    logic [XLEN-1:0] rem_out_r;

    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op_b_s;
    logic            neg_a_s;
    logic            neg_b_s;
    logic [XLEN-1:0] abs_a_s;
    logic [XLEN-1:0] abs_b_s;
    logic            div0_s;
    logic            ovf_s;
    logic            accept_s;
    logic [XLEN:0]   shifted_s;
    logic            qbit_s;
    logic [XLEN-1:0] diff_s;
    logic [XLEN-1:0] q_mag_s;
    logic [XLEN-1:0] r_mag_s;
    logic [XLEN-1:0] q_fix_s;
    logic [XLEN-1:0] r_fix_s;

    // Operand decode: width/sign extension, magnitudes and special-case detection.
    always_comb begin
        op_a_s = ZERO;
        op_b_s = ZERO;
        if (bus.div_word) begin
            if (bus.div_signed) begin
                op_a_s = sext32(bus.rs1_data[31:0]);
                op_b_s = sext32(bus.rs2_data[31:0]);
            end else begin
                op_a_s = {{(XLEN-32){1'b0}}, bus.rs1_data[31:0]};
                op_b_s = {{(XLEN-32){1'b0}}, bus.rs2_data[31:0]};
            end
        end else begin
            op_a_s = bus.rs1_data;
            op_b_s = bus.rs2_data;
        end
        neg_a_s  = bus.div_signed & op_a_s[XLEN-1];
        neg_b_s  = bus.div_signed & op_b_s[XLEN-1];
        abs_a_s  = neg_a_s ? (ZERO - op_a_s) : op_a_s;
        abs_b_s  = neg_b_s ? (ZERO - op_b_s) : op_b_s;
        div0_s   = (op_b_s == ZERO);
        ovf_s    = bus.div_signed & (op_b_s == ALL_ONES)
                 & (op_a_s == (bus.div_word ? MIN_WORD : MIN_DWORD));
        accept_s = bus.in_valid & (state_r == ST_IDLE) & ~flush;
    end

    // One restoring step. The true difference always fits XLEN bits when it is
    // kept, so the subtraction is done modulo 2^XLEN.
    always_comb begin
        shifted_s = {rem_r, dvd_r[XLEN-1]};
        qbit_s    = (shifted_s >= {1'b0, dsr_r});
        diff_s    = shifted_s[XLEN-1:0] - dsr_r;
    end

    // Sign fix-up; word results are re-extended from bit 31 for signed and unsigned ops alike.
    always_comb begin
        q_mag_s = neg_q_r ? (ZERO - dvd_r) : dvd_r;
        r_mag_s = neg_r_r ? (ZERO - rem_r) : rem_r;
        if (word_r) begin
            q_fix_s = sext32(q_mag_s[31:0]);
            r_fix_s = sext32(r_mag_s[31:0]);
        end else begin
            q_fix_s = q_mag_s;
            r_fix_s = r_mag_s;
        end
    end

    // Next-state logic; flush overrides every state.
    always_comb begin
        state_next = state_r;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_next = (div0_s | ovf_s) ? ST_DONE : ST_CALC;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_next = ST_FIX;
                    end else begin
                        state_next = ST_CALC;
                    end
                end
                ST_FIX:  state_next = ST_DONE;
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State register plus registered handshake outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next;
            in_ready_r  <= (state_next == ST_IDLE);
            out_valid_r <= (state_next == ST_DONE);
        end
    end

    // Datapath: operand capture, iteration, result registration. A flush freezes
    // everything, so result registers keep their stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CW{1'b0}};
            dvd_r     <= ZERO;
            dsr_r     <= ZERO;
            rem_r     <= ZERO;
            word_r    <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            quo_out_r <= ZERO;
            rem_out_r <= ZERO;
        end else if (!flush) begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        word_r  <= bus.div_word;
                        neg_q_r <= neg_a_s ^ neg_b_s;
                        neg_r_r <= neg_a_s;
                        dsr_r   <= abs_b_s;
                        rem_r   <= ZERO;
                        // Word dividends are left-aligned so the MSB feed is identical for both widths.
                        dvd_r   <= bus.div_word ? {abs_a_s[31:0], {(XLEN-32){1'b0}}} : abs_a_s;
                        cnt_r   <= bus.div_word ? CNT_WORD : CNT_DWORD;
                        if (div0_s) begin
                            quo_out_r <= ALL_ONES;
                            rem_out_r <= bus.div_word ? sext32(bus.rs1_data[31:0]) : bus.rs1_data;
                        end else if (ovf_s) begin
                            quo_out_r <= op_a_s;
                            rem_out_r <= ZERO;
                        end
                    end
                end
                ST_CALC: begin
                    rem_r <= qbit_s ? diff_s : shifted_s[XLEN-1:0];
                    dvd_r <= {dvd_r[XLEN-2:0], qbit_s};
                    if (cnt_r != {CW{1'b0}}) begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_FIX: begin
                    quo_out_r <= q_fix_s;
                    rem_out_r <= r_fix_s;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.quotient  = quo_out_r;
    assign bus.remainder = rem_out_r;

endmodule

// File: tb/tb_iter_div.sv
// ---------------------------------------------------------------------------
// tb_iter_div
//   Directed self-checking bench for iter_div. Expected values are hand
//   computed. Latency is counted as rising edges after the accept edge until
//   out_valid is seen: N+1 for a normal op; special cases raise out_valid on
//   the accept edge itself, so they are already valid in the first cycle
//   after accept and the edge count is 0.
// ---------------------------------------------------------------------------
module tb_iter_div;

    logic clk;
    logic rst_n;
    logic flush;
    int   errors;
    int   checks;

    iter_div_if #(.XLEN(64)) bus ();

    iter_div #(.XLEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, check latency/results/stability, then complete the handshake.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic sgn, input logic wd,
                          input logic [63:0] eq, input logic [63:0] er,
                          input int elat, input int hold);
        int          lat;
        bit          stable;
        logic [63:0] q0;
        logic [63:0] r0;
        @(negedge clk);
        bus.rs1_data   = a;
        bus.rs2_data   = b;
        bus.div_signed = sgn;
        bus.div_word   = wd;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b0;
        chk({tag, "/in_ready_idle"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after the accept edge; they must not matter.
        bus.in_valid   = 1'b0;
        bus.rs1_data   = ~a;
        bus.rs2_data   = b ^ 64'h5;
        bus.div_signed = ~sgn;
        bus.div_word   = ~wd;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "/latency"}, 64'(lat), 64'(elat));
        chk({tag, "/quotient"}, bus.quotient, eq);
        chk({tag, "/remainder"}, bus.remainder, er);
        chk({tag, "/in_ready_busy"}, 64'(bus.in_ready), 64'd0);
        stable = 1'b1;
        q0 = bus.quotient;
        r0 = bus.remainder;
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (bus.quotient !== q0 || bus.remainder !== r0 ||
                bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk({tag, "/hold_stable"}, 64'(stable), 64'd1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "/out_valid_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "/in_ready_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    // Watch out_valid for a number of cycles; it must stay low.
    task automatic quiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        chk({tag, "/no_out_valid"}, 64'(seen), 64'd0);
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.rs1_data   = 64'd0;
        bus.rs2_data   = 64'd0;
        bus.div_signed = 1'b0;
        bus.div_word   = 1'b0;
        bus.out_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst/in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst/out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst/quotient", bus.quotient, 64'd0);
        chk("rst/remainder", bus.remainder, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Main function, signed/unsigned, dword/word
        run_op("div_100_7", 64'd100, 64'd7, 1'b1, 1'b0, 64'd14, 64'd2, 65, 0);
        run_op("div_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run_op("div_7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65, 0);
        run_op("divu_big_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b0,
               64'h7FFF_FFFF_FFFF_FFFC, 64'd1, 65, 0);
        run_op("divu_max_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
               64'd1, 64'd0, 65, 0);
        run_op("div_maxpos_m1", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               64'h8000_0000_0000_0001, 64'd0, 65, 0);
        run_op("div_m1_maxpos", 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run_op("divu_0_5", 64'd0, 64'd5, 1'b0, 1'b0, 64'd0, 64'd0, 65, 0);

        // Special cases: divide by zero and signed overflow
        run_op("div_5_0", 64'd5, 64'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 0, 0);
        run_op("divw_5_0", 64'd5, 64'hABCD_0000_0000_0000, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 0, 0);
        run_op("divuw_x_0", 64'hFFFF_FFFF_8000_0005, 64'd0, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, 0, 0);
        run_op("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               64'h8000_0000_0000_0000, 64'd0, 0, 0);
        run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
               64'hFFFF_FFFF_8000_0000, 64'd0, 0, 0);

        // Word ops: 33-cycle latency, upper operand bits ignored, results sign-extended
        run_op("divuw_sext", 64'hFFFF_FFFF_8000_0000, 64'd1, 1'b0, 1'b1,
               64'hFFFF_FFFF_8000_0000, 64'd0, 33, 0);
        run_op("divuw_ffff_16", 64'h1234_5678_FFFF_FFFF, 64'hABCD_0000_0000_0010, 1'b0, 1'b1,
               64'h0000_0000_0FFF_FFFF, 64'h0000_0000_0000_000F, 33, 0);
        run_op("divuw_fffe_1", 64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 33, 0);
        run_op("divw_m7_2", 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
        run_op("divw_100_m7", 64'hDEAD_BEEF_0000_0064, 64'h0000_0000_FFFF_FFF9, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 33, 0);

        // Back-pressure: hold out_ready low 20 cycles in DONE
        run_op("hold_100_7", 64'd100, 64'd7, 1'b1, 1'b0, 64'd14, 64'd2, 65, 20);

        // Flush at iteration 10 with a would-be special request presented the same cycle
        @(negedge clk);
        bus.rs1_data = 64'd1000; bus.rs2_data = 64'd7;
        bus.div_signed = 1'b1; bus.div_word = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        bus.in_valid = 1'b1; bus.rs1_data = 64'd9; bus.rs2_data = 64'd0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_calc/out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_calc/in_ready", 64'(bus.in_ready), 64'd1);
        quiet("flush_calc", 70);
        run_op("after_flush_9_3", 64'd9, 64'd3, 1'b1, 1'b0, 64'd3, 64'd0, 65, 0);

        // Flush in IDLE with in_valid high: request ignored
        @(negedge clk);
        flush = 1'b1;
        bus.in_valid = 1'b1; bus.rs1_data = 64'd5; bus.rs2_data = 64'd0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_idle/out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_idle/in_ready", 64'(bus.in_ready), 64'd1);
        quiet("flush_idle", 3);

        // Flush in DONE together with out_ready: result dropped, back to IDLE
        @(negedge clk);
        bus.rs1_data = 64'd5; bus.rs2_data = 64'd0;
        bus.div_signed = 1'b0; bus.div_word = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("flush_done/pre_out_valid", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_done/out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_done/in_ready", 64'(bus.in_ready), 64'd1);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        bus.rs1_data = 64'd100; bus.rs2_data = 64'd7;
        bus.div_signed = 1'b1; bus.div_word = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid/in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mid/out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid/quotient", bus.quotient, 64'd0);
        chk("rst_mid/remainder", bus.remainder, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet("rst_mid", 70);
        run_op("after_rst_9_3", 64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 64'd0, 65, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
